// File: rtl/vx_fpu_fma_issue_pkg.sv
// vx_fpu_fma_issue_pkg: FMA opcodes, control triple and shared field widths
package vx_fpu_fma_issue_pkg;
   localparam int INST_FRM_BITS = 3;
   localparam int FP_FLAGS_BITS = 5;
   localparam logic [2:0] FMA_OP_ADD   = 3'd0;
   localparam logic [2:0] FMA_OP_SUB   = 3'd1;
   localparam logic [2:0] FMA_OP_MUL   = 3'd2;
   localparam logic [2:0] FMA_OP_MADD  = 3'd3;
   localparam logic [2:0] FMA_OP_MSUB  = 3'd4;
   localparam logic [2:0] FMA_OP_NMSUB = 3'd5;
   localparam logic [2:0] FMA_OP_NMADD = 3'd6;
   typedef struct packed {
      logic is_madd;
      logic is_sub;
      logic is_neg;
   } fma_ctrl_t;
endpackage

// File: rtl/vx_fpu_fma_issue_if.sv
// vx_fpu_fma_issue_if: request, FMA-unit and response buses of the FMA issue block
interface vx_fpu_fma_issue_if import vx_fpu_fma_issue_pkg::*; #(
   parameter int NUM_LANES   = 1,
   parameter int TAG_WIDTH   = 1,
   parameter int MAX_PENDING = 8
);
   localparam int DW = NUM_LANES * 32;
   localparam int PW = $clog2(MAX_PENDING + 1);
   logic req_valid, req_ready;
   logic [2:0] req_op;
   logic [INST_FRM_BITS-1:0] req_frm;
   logic [NUM_LANES-1:0] req_mask;
   logic [TAG_WIDTH-1:0] req_tag;
   logic [DW-1:0] req_dataa, req_datab, req_datac;
   logic fma_valid_in, fma_ready_in;
   logic [NUM_LANES-1:0] fma_mask_in;
   logic [TAG_WIDTH-1:0] fma_tag_in;
   logic [INST_FRM_BITS-1:0] fma_frm;
   logic [DW-1:0] fma_dataa, fma_datab, fma_datac;
   logic fma_is_madd, fma_is_sub, fma_is_neg;
   logic fma_valid_out, fma_ready_out;
   logic [DW-1:0] fma_result;
   logic fma_has_fflags;
   logic [FP_FLAGS_BITS-1:0] fma_fflags;
   logic [TAG_WIDTH-1:0] fma_tag_out;
   logic rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_result;
   logic [FP_FLAGS_BITS-1:0] rsp_fflags;
   logic [TAG_WIDTH-1:0] rsp_tag;
   logic [FP_FLAGS_BITS-1:0] acc_fflags;
   logic acc_clear, illegal_op;
   logic [PW-1:0] pending;
   modport slave (
      input  req_valid, req_op, req_frm, req_mask, req_tag, req_dataa, req_datab, req_datac,
      output req_ready,
      output fma_valid_in, fma_mask_in, fma_tag_in, fma_frm, fma_dataa, fma_datab, fma_datac,
      output fma_is_madd, fma_is_sub, fma_is_neg,
      input  fma_ready_in,
      input  fma_valid_out, fma_result, fma_has_fflags, fma_fflags, fma_tag_out,
      output fma_ready_out,
      output rsp_valid, rsp_result, rsp_fflags, rsp_tag,
      input  rsp_ready,
      output acc_fflags, illegal_op, pending,
      input  acc_clear
   );
   modport master (
      output req_valid, req_op, req_frm, req_mask, req_tag, req_dataa, req_datab, req_datac,
      input  req_ready,
      input  fma_valid_in, fma_mask_in, fma_tag_in, fma_frm, fma_dataa, fma_datab, fma_datac,
      input  fma_is_madd, fma_is_sub, fma_is_neg,
      output fma_ready_in,
      output fma_valid_out, fma_result, fma_has_fflags, fma_fflags, fma_tag_out,
      input  fma_ready_out,
      input  rsp_valid, rsp_result, rsp_fflags, rsp_tag,
      output rsp_ready,
      input  acc_fflags, illegal_op, pending,
      output acc_clear
   );
endinterface

// File: rtl/vx_fpu_fma_issue_decode.sv
// vx_fpu_fma_issue_decode: maps an FPU arithmetic opcode onto the FMA control triple
module vx_fpu_fma_issue_decode import vx_fpu_fma_issue_pkg::*; (
   input  logic [2:0] op,
   output fma_ctrl_t  ctrl,
   output logic       illegal
);
   // the reserved opcode falls through to all-zero controls, i.e. ADD
   always_comb begin
      ctrl.is_madd = op inside {FMA_OP_MADD, FMA_OP_MSUB, FMA_OP_NMSUB, FMA_OP_NMADD};
      ctrl.is_sub  = op inside {FMA_OP_SUB, FMA_OP_MSUB, FMA_OP_NMSUB};
      ctrl.is_neg  = op inside {FMA_OP_MUL, FMA_OP_NMSUB, FMA_OP_NMADD};
      illegal      = op > FMA_OP_NMADD;
   end
endmodule

// File: rtl/vx_fpu_fma_issue.sv
// vx_fpu_fma_issue: credit-limited issue of decoded FPU requests to the FMA unit with skid-buffered responses
module vx_fpu_fma_issue import vx_fpu_fma_issue_pkg::*; #(
   parameter int NUM_LANES   = 1,
   parameter int TAG_WIDTH   = 1,
   parameter int MAX_PENDING = 8
) (
   input logic clk,
   input logic reset,
   vx_fpu_fma_issue_if.slave bus
);
   localparam int DW = NUM_LANES * 32;
   localparam int PW = $clog2(MAX_PENDING + 1);
   localparam int IW = 3 + NUM_LANES + TAG_WIDTH + INST_FRM_BITS + 3 * DW;
   localparam int RW = DW + FP_FLAGS_BITS + TAG_WIDTH;
   fma_ctrl_t ctrl;
   logic illegal;
   logic [IW-1:0] req_pl, iss_pl, iss_skid;
   logic iss_valid, iss_skid_valid;
   logic [RW-1:0] rsp_in, rsp_pl, rsp_skid;
   logic rsp_valid_q, rsp_skid_valid;
   logic [PW-1:0] pending_q;
   logic [PW+1:0] in_flight;
   logic [FP_FLAGS_BITS-1:0] acc_q;
   logic illegal_q;
   logic req_fire, iss_fire, fma_out_fire, rsp_fire;
   vx_fpu_fma_issue_decode dec (.op(bus.req_op), .ctrl, .illegal);
   assign req_pl = {ctrl, bus.req_mask, bus.req_tag, bus.req_frm, bus.req_dataa, bus.req_datab, bus.req_datac};
   // staged entries hold a credit too, so a full issue stage can never overshoot the limit
   assign in_flight = (PW+2)'(pending_q) + (PW+2)'(iss_valid) + (PW+2)'(iss_skid_valid);
   assign bus.req_ready = !iss_skid_valid && in_flight < (PW+2)'(MAX_PENDING);
   assign req_fire = bus.req_valid && bus.req_ready;
   assign iss_fire = iss_valid && bus.fma_ready_in;
   assign bus.fma_valid_in = iss_valid;
   assign {bus.fma_is_madd, bus.fma_is_sub, bus.fma_is_neg, bus.fma_mask_in, bus.fma_tag_in,
           bus.fma_frm, bus.fma_dataa, bus.fma_datab, bus.fma_datac} = iss_pl;
   always_ff @(posedge clk) begin
      if (reset) begin
         iss_valid <= 1'b0;
         iss_skid_valid <= 1'b0;
      end else if (bus.fma_ready_in || !iss_valid) begin
         iss_valid <= iss_skid_valid || req_fire;
         iss_skid_valid <= 1'b0;
         iss_pl <= iss_skid_valid ? iss_skid : req_pl;
      end else if (req_fire) begin
         iss_skid_valid <= 1'b1;
         iss_skid <= req_pl;
      end
   end
   assign rsp_in = {bus.fma_result, {FP_FLAGS_BITS{bus.fma_has_fflags}} & bus.fma_fflags, bus.fma_tag_out};
   assign bus.fma_ready_out = !rsp_skid_valid;
   assign fma_out_fire = bus.fma_valid_out && !rsp_skid_valid;
   assign rsp_fire = rsp_valid_q && bus.rsp_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign {bus.rsp_result, bus.rsp_fflags, bus.rsp_tag} = rsp_pl;
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_skid_valid <= 1'b0;
      end else if (bus.rsp_ready || !rsp_valid_q) begin
         rsp_valid_q <= rsp_skid_valid || fma_out_fire;
         rsp_skid_valid <= 1'b0;
         rsp_pl <= rsp_skid_valid ? rsp_skid : rsp_in;
      end else if (fma_out_fire) begin
         rsp_skid_valid <= 1'b1;
         rsp_skid <= rsp_in;
      end
   end
   // a clear coinciding with a retire keeps only the retiring flags
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         acc_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         pending_q <= pending_q + PW'(iss_fire) - PW'(rsp_fire);
         if (req_fire && illegal) illegal_q <= 1'b1;
         if (rsp_fire || bus.acc_clear) acc_q <= (bus.acc_clear ? '0 : acc_q) | (rsp_fire ? bus.rsp_fflags : '0);
      end
   end
   assign bus.pending = pending_q;
   assign bus.acc_fflags = acc_q;
   assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_vx_fpu_fma_issue.sv
// tb_vx_fpu_fma_issue: vector table, directed corners and randomized scoreboard run against an FMA-unit model
`timescale 1ns/1ps
module tb_vx_fpu_fma_issue;
   import vx_fpu_fma_issue_pkg::*;
   localparam int TW = 4;
   localparam int MP = 2;
   typedef struct {
      logic [2:0] op;
      logic [TW-1:0] tag;
      logic m;
      logic [2:0] frm;
      logic [31:0] a, b, c;
      logic [4:0] fl;
      logic has;
   } req_t;
   typedef struct { logic [TW-1:0] tag; logic [31:0] res; logic [4:0] fl; } rsp_t;
   typedef struct { logic [31:0] res; logic [TW-1:0] tag; logic [4:0] fl; logic has; } fma_t;
   typedef struct { logic [2:0] op; logic [2:0] ctrl; logic [31:0] res; } vec_t;
   logic clk = 0, reset = 1;
   always #5 clk = ~clk;
   vx_fpu_fma_issue_if #(.NUM_LANES(1), .TAG_WIDTH(TW), .MAX_PENDING(MP)) bus ();
   vx_fpu_fma_issue #(.NUM_LANES(1), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (.clk(clk), .reset(reset), .bus(bus));
   req_t rq[$], iq[$];
   rsp_t sq[$];
   fma_t fq[$];
   logic [TW-1:0] got_tags[$];
   vec_t vt[8];
   int passed = 0, total = 0;
   int fma_mode = 0, rsp_mode = 1, issued = 0, retired = 0, pend_m = 0;
   bit fma_fast = 1, clr_rand = 0, clr_nxt = 0, out_done = 0, stalled = 0;
   logic [4:0] acc_m = 0;
   logic [2:0] last_ctrl;
   logic [31:0] last_res;
   logic [106:0] stall_pl, cur_pl;
   localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   function automatic real f2r(logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = 11'(f[30:23]) + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction
   function automatic logic [31:0] r2f(real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction
   function automatic logic [31:0] exp_res(logic [2:0] op, logic [31:0] fa, logic [31:0] fb, logic [31:0] fc);
      real a, b, c;
      a = f2r(fa); b = f2r(fb); c = f2r(fc);
      case (op)
         FMA_OP_SUB:   return r2f(a - c);
         FMA_OP_MUL:   return r2f(a * b);
         FMA_OP_MADD:  return r2f(a * b + c);
         FMA_OP_MSUB:  return r2f(a * b - c);
         FMA_OP_NMSUB: return r2f(-(a * b - c));
         FMA_OP_NMADD: return r2f(-(a * b + c));
         default:      return r2f(a + c);
      endcase
   endfunction
   function automatic logic [2:0] exp_ctrl(logic [2:0] op);
      case (op)
         3'd1: return 3'b010;
         3'd2: return 3'b001;
         3'd3: return 3'b100;
         3'd4: return 3'b110;
         3'd5: return 3'b111;
         3'd6: return 3'b101;
         default: return 3'b000;
      endcase
   endfunction
   // behaviour of the external FMA unit, driven only by the control triple it receives
   function automatic logic [31:0] fma_unit(logic madd, logic sub, logic neg, logic [31:0] fa, logic [31:0] fb, logic [31:0] fc);
      real a, b, c, r;
      a = f2r(fa); b = f2r(fb); c = f2r(fc);
      r = madd ? a * b + (sub ? -c : c) : neg ? a * b : a + (sub ? -c : c);
      return r2f(madd && neg ? -r : r);
   endfunction
   function automatic req_t mk(logic [2:0] op, logic [TW-1:0] tag, logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [4:0] fl, logic has);
      req_t r;
      r.op = op; r.tag = tag; r.m = 1'($urandom); r.frm = 3'($urandom_range(0, 4));
      r.a = a; r.b = b; r.c = c; r.fl = fl; r.has = has;
      return r;
   endfunction
   task automatic step();
      logic rf, isf, of, sf;
      @(posedge clk); #1;
      bus.req_valid = rq.size() != 0;
      if (rq.size() != 0) begin
         bus.req_op = rq[0].op; bus.req_tag = rq[0].tag; bus.req_mask = rq[0].m; bus.req_frm = rq[0].frm;
         bus.req_dataa = rq[0].a; bus.req_datab = rq[0].b; bus.req_datac = rq[0].c;
      end
      bus.fma_ready_in = fma_mode == 0 ? 1'b1 : fma_mode == 1 ? ~bus.fma_ready_in : 1'($urandom);
      bus.rsp_ready = rsp_mode == 0 ? 1'b0 : rsp_mode == 1 ? 1'b1 : 1'($urandom);
      bus.acc_clear = clr_nxt || (clr_rand && $urandom_range(0, 15) == 0);
      clr_nxt = 0;
      if (out_done) begin bus.fma_valid_out = 0; out_done = 0; end
      if (!bus.fma_valid_out && fq.size() != 0 && (fma_fast || $urandom_range(0, 1) == 1)) begin
         bus.fma_valid_out = 1; bus.fma_result = fq[0].res; bus.fma_tag_out = fq[0].tag;
         bus.fma_fflags = fq[0].fl; bus.fma_has_fflags = fq[0].has;
      end
      @(negedge clk);
      rf = bus.req_valid && bus.req_ready;
      isf = bus.fma_valid_in && bus.fma_ready_in;
      of = bus.fma_valid_out && bus.fma_ready_out;
      sf = bus.rsp_valid && bus.rsp_ready;
      cur_pl = {bus.fma_is_madd, bus.fma_is_sub, bus.fma_is_neg, bus.fma_mask_in, bus.fma_tag_in, bus.fma_frm,
                bus.fma_dataa, bus.fma_datab, bus.fma_datac};
      check("acc_fflags", 64'(bus.acc_fflags), 64'(acc_m));
      check("pending", 64'(bus.pending), 64'(pend_m));
      if (stalled) begin
         check("stall_valid", 64'(bus.fma_valid_in), 64'd1);
         check("stall_payload_stable", 64'(cur_pl == stall_pl), 64'd1);
      end
      if (isf) begin
         issued++;
         check("issue_expected", 64'(iq.size() != 0), 64'd1);
         if (iq.size() != 0) begin
            req_t r;
            r = iq.pop_front();
            last_ctrl = {bus.fma_is_madd, bus.fma_is_sub, bus.fma_is_neg};
            check("issue_tag", 64'(bus.fma_tag_in), 64'(r.tag));
            check("issue_ctrl", 64'(last_ctrl), 64'(exp_ctrl(r.op)));
            check("issue_abc", {bus.fma_dataa, bus.fma_datac}, {r.a, r.c});
            check("issue_b_mask_frm", {bus.fma_datab, bus.fma_mask_in, bus.fma_frm}, {r.b, r.m, r.frm});
            fq.push_back('{fma_unit(bus.fma_is_madd, bus.fma_is_sub, bus.fma_is_neg, bus.fma_dataa, bus.fma_datab, bus.fma_datac),
                           bus.fma_tag_in, r.fl, r.has});
         end
      end
      if (rf) begin
         req_t r;
         r = rq.pop_front();
         iq.push_back(r);
         sq.push_back('{r.tag, exp_res(r.op, r.a, r.b, r.c), r.has ? r.fl : 5'd0});
      end
      if (of) begin void'(fq.pop_front()); out_done = 1; end
      if (sf) begin
         retired++;
         got_tags.push_back(bus.rsp_tag);
         last_res = bus.rsp_result;
         check("rsp_expected", 64'(sq.size() != 0), 64'd1);
         if (sq.size() != 0) begin
            rsp_t e;
            e = sq.pop_front();
            check("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
            check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
            check("rsp_fflags", 64'(bus.rsp_fflags), 64'(e.fl));
            acc_m = (bus.acc_clear ? 5'd0 : acc_m) | e.fl;
         end
      end else if (bus.acc_clear) acc_m = 0;
      pend_m += int'(isf) - int'(sf);
      check("pending_bound", 64'(pend_m >= 0 && pend_m <= MP), 64'd1);
      stalled = bus.fma_valid_in && !bus.fma_ready_in;
      stall_pl = cur_pl;
   endtask
   task automatic run_until_retired(int n, int budget);
      int t0;
      t0 = retired;
      for (int i = 0; i < budget && retired < t0 + n; i++) step();
      check("retire_count", 64'(retired - t0), 64'(n));
   endtask
   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1; bus.req_valid = 0; bus.fma_valid_out = 0; bus.acc_clear = 0;
      rq.delete(); iq.delete(); sq.delete(); fq.delete();
      pend_m = 0; acc_m = 0; out_done = 0; stalled = 0;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      check("rst_pending", 64'(bus.pending), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_fma_valid_in", 64'(bus.fma_valid_in), 64'd0);
      check("rst_acc_illegal", 64'({bus.acc_fflags, bus.illegal_op}), 64'd0);
   endtask
   initial begin
      bus.req_valid = 0; bus.req_op = 0; bus.req_frm = 0; bus.req_mask = 0; bus.req_tag = 0;
      bus.req_dataa = 0; bus.req_datab = 0; bus.req_datac = 0; bus.fma_ready_in = 0;
      bus.fma_valid_out = 0; bus.fma_result = 0; bus.fma_has_fflags = 0; bus.fma_fflags = 0;
      bus.fma_tag_out = 0; bus.rsp_ready = 0; bus.acc_clear = 0;
      vt[0] = '{3'd0, 3'b000, 32'h40400000};
      vt[1] = '{3'd1, 3'b010, 32'h3F800000};
      vt[2] = '{3'd2, 3'b001, 32'h40C00000};
      vt[3] = '{3'd3, 3'b100, 32'h40E00000};
      vt[4] = '{3'd4, 3'b110, 32'h40A00000};
      vt[5] = '{3'd5, 3'b111, 32'hC0A00000};
      vt[6] = '{3'd6, 3'b101, 32'hC0E00000};
      vt[7] = '{3'd7, 3'b000, 32'h40400000};
      repeat (2) @(posedge clk);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rq.push_back(mk(vt[i].op, TW'(i), F2, F3, F1, 5'd0, 1'b0));
         run_until_retired(1, 40);
         check($sformatf("vec%0d_ctrl", i), 64'(last_ctrl), 64'(vt[i].ctrl));
         check($sformatf("vec%0d_result", i), 64'(last_res), 64'(vt[i].res));
      end
      step();
      check("illegal_sticky", 64'(bus.illegal_op), 64'd1);
      fma_mode = 0; rsp_mode = 0;
      issued = 0; got_tags.delete();
      for (int i = 0; i < 5; i++) rq.push_back(mk(3'(i % 7), TW'(i), F2, F3, F1, 5'd0, 1'b0));
      repeat (15) step();
      check("credit_issued", 64'(issued), 64'd2);
      check("credit_req_ready", 64'(bus.req_ready), 64'd0);
      check("credit_pending", 64'(bus.pending), 64'd2);
      check("credit_waiting", 64'(rq.size()), 64'd3);
      rsp_mode = 1;
      run_until_retired(5, 80);
      for (int i = 0; i < 5; i++) check($sformatf("order_tag%0d", i), 64'(got_tags[i]), 64'(i));
      fma_mode = 1;
      for (int i = 0; i < 20; i++) rq.push_back(mk(3'($urandom_range(0, 6)), TW'(i), F2, F3, F1, 5'd0, 1'b0));
      run_until_retired(20, 400);
      fma_mode = 0; clr_nxt = 1;
      step();
      rq.push_back(mk(3'd0, 4'd1, F2, F3, F1, 5'h01, 1'b1));
      rq.push_back(mk(3'd0, 4'd2, F2, F3, F1, 5'h05, 1'b1));
      run_until_retired(2, 40);
      step();
      check("acc_nx_of", 64'(bus.acc_fflags), 64'h05);
      rq.push_back(mk(3'd1, 4'd3, F2, F3, F1, 5'h1F, 1'b0));
      rq.push_back(mk(3'd1, 4'd4, F2, F3, F1, 5'h02, 1'b1));
      run_until_retired(2, 40);
      step();
      check("acc_uf_added", 64'(bus.acc_fflags), 64'h07);
      rsp_mode = 0;
      rq.push_back(mk(3'd3, 4'd5, F2, F3, F1, 5'h05, 1'b1));
      for (int i = 0; i < 40 && !bus.rsp_valid; i++) step();
      check("acc_rsp_waiting", 64'(bus.rsp_valid), 64'd1);
      rsp_mode = 1; clr_nxt = 1;
      step();
      step();
      check("acc_clear_with_fire", 64'(bus.acc_fflags), 64'h05);
      fma_mode = 2; rsp_mode = 2; fma_fast = 0; clr_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         if (rq.size() < 2 && $urandom_range(0, 3) != 0)
            rq.push_back(mk(3'($urandom), TW'($urandom), r2f(real'($urandom_range(1, 9))), r2f(real'($urandom_range(1, 9))),
                            r2f(real'($urandom_range(1, 9))), 5'($urandom), 1'($urandom)));
         step();
      end
      fma_mode = 0; rsp_mode = 1; fma_fast = 1; clr_rand = 0;
      for (int i = 0; i < 100 && (rq.size() != 0 || sq.size() != 0); i++) step();
      check("random_drained", 64'(rq.size() + sq.size()), 64'd0);
      rsp_mode = 0;
      rq.push_back(mk(3'd0, 4'd7, F2, F3, F1, 5'd0, 1'b0));
      rq.push_back(mk(3'd0, 4'd8, F2, F3, F1, 5'd0, 1'b0));
      repeat (10) step();
      check("pre_reset_pending", 64'(bus.pending), 64'd2);
      check("pre_reset_illegal", 64'(bus.illegal_op), 64'd1);
      do_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
